riscv_control_unit: RTL and testbench



---
 rtl/riscv_control_unit.sv | 136 +++++++++++++
 tb/tb_riscv_control_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_control_unit.sv
// riscv_control_unit: main control unit for a single-cycle RV32I core.
//
// It decodes opcode, funct3 and funct7[5] into datapath controls. All control
// outputs are combinational. The only state is a sticky flag that records an
// unsupported opcode seen since the last reset.
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high
//   zero       in   1  ALU zero flag (beq)
//   op         in   7  instruction[6:0]
//   f3         in   3  instruction[14:12]
//   f7         in   1  instruction[30]
//   pcSrc      out  1  0 = PC+4, 1 = PC+imm
//   resSrc     out  2  00 ALU, 01 memory, 10 PC+4
//   memWrite   out  1  data memory write enable
//   aluControl out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//   aluSrc     out  1  0 = rs2, 1 = immediate
//   immSrc     out  2  00 I, 01 S, 10 B, 11 J
//   regWrite   out  1  register file write enable
//   illegal    out  1  sticky unsupported-opcode flag, 1-cycle latency
module riscv_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       zero,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic       f7,
    output logic       pcSrc,
    output logic [1:0] resSrc,
    output logic       memWrite,
    output logic [2:0] aluControl,
    output logic       aluSrc,
    output logic [1:0] immSrc,
    output logic       regWrite,
    output logic       illegal
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    logic       reg_write_dec;
    logic       mem_write_dec;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal_now;
    logic       illegal_d;
    logic       illegal_q;

    // Main decoder
    always_comb begin
        reg_write_dec = 1'b0;
        immSrc        = 2'b00;
        aluSrc        = 1'b0;
        mem_write_dec = 1'b0;
        resSrc        = 2'b00;
        branch        = 1'b0;
        alu_op        = 2'b00;
        jump          = 1'b0;
        illegal_now   = 1'b0;
        case (op)
            OpLoad: begin
                reg_write_dec = 1'b1;
                aluSrc        = 1'b1;
                resSrc        = 2'b01;
            end
            OpStore: begin
                immSrc        = 2'b01;
                aluSrc        = 1'b1;
                mem_write_dec = 1'b1;
            end
            OpReg: begin
                reg_write_dec = 1'b1;
                alu_op        = 2'b10;
            end
            OpBranch: begin
                immSrc = 2'b10;
                branch = 1'b1;
                alu_op = 2'b01;
            end
            OpImm: begin
                reg_write_dec = 1'b1;
                aluSrc        = 1'b1;
                alu_op        = 2'b10;
            end
            OpJal: begin
                reg_write_dec = 1'b1;
                immSrc        = 2'b11;
                resSrc        = 2'b10;
                jump          = 1'b1;
            end
            default: illegal_now = 1'b1;
        endcase
    end

    // ALU decoder; op[5] separates R-type from I-type so addi never subtracts
    always_comb begin
        aluControl = 3'b000;
        case (alu_op)
            2'b01: aluControl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  aluControl = (op[5] & f7) ? 3'b001 : 3'b000;
                    3'b010:  aluControl = 3'b101;
                    3'b110:  aluControl = 3'b011;
                    3'b111:  aluControl = 3'b010;
                    default: aluControl = 3'b000;
                endcase
            end
            default: aluControl = 3'b000;
        endcase
    end

    // State-changing enables are suppressed while reset is held
    always_comb begin
        pcSrc    = ((branch & zero) | jump) & ~rst;
        regWrite = reg_write_dec & ~rst;
        memWrite = mem_write_dec & ~rst;
    end

    always_comb begin
        illegal_d = rst ? 1'b0 : (illegal_q | illegal_now);
    end

    always_ff @(posedge clk) begin
        illegal_q <= illegal_d;
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_riscv_control_unit.sv
module tb_riscv_control_unit;

    logic       clk;
    logic       rst;
    logic       zero;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       pcSrc;
    logic [1:0] resSrc;
    logic       memWrite;
    logic [2:0] aluControl;
    logic       aluSrc;
    logic [1:0] immSrc;
    logic       regWrite;
    logic       illegal;

    riscv_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .zero       (zero),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .pcSrc      (pcSrc),
        .resSrc     (resSrc),
        .memWrite   (memWrite),
        .aluControl (aluControl),
        .aluSrc     (aluSrc),
        .immSrc     (immSrc),
        .regWrite   (regWrite),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc;
        logic [1:0] res;
        logic       mw;
        logic [2:0] alu;
        logic       asrc;
        logic [1:0] imm;
        logic       rw;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    // Reference model state
    bit model_ill = 0;
    bit prev_rst  = 1;
    bit prev_bad  = 0;

    localparam bit [6:0] LW   = 7'b0000011;
    localparam bit [6:0] SW   = 7'b0100011;
    localparam bit [6:0] RTYP = 7'b0110011;
    localparam bit [6:0] BEQ  = 7'b1100011;
    localparam bit [6:0] ITYP = 7'b0010011;
    localparam bit [6:0] JAL  = 7'b1101111;

    function automatic bit is_legal(bit [6:0] o);
        return o inside {LW, SW, RTYP, BEQ, ITYP, JAL};
    endfunction

    // Arithmetic operation requested by an R/I instruction, as ALU code
    function automatic bit [2:0] arith(bit [2:0] fn3, bit is_sub);
        case (fn3)
            3'd0:    return is_sub ? 3'b001 : 3'b000; // sub / add
            3'd2:    return 3'b101;                   // slt
            3'd6:    return 3'b011;                   // or
            3'd7:    return 3'b010;                   // and
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t model(bit r, bit z, bit [6:0] o, bit [2:0] fn3, bit ff7, bit ill);
        exp_t e;
        e = '0;
        if (o == LW) begin
            e.rw = 1; e.res = 2'b01; e.asrc = 1; e.imm = 2'b00;
        end else if (o == SW) begin
            e.mw = 1; e.asrc = 1; e.imm = 2'b01;
        end else if (o == RTYP) begin
            e.rw = 1; e.alu = arith(fn3, ff7);
        end else if (o == ITYP) begin
            e.rw = 1; e.asrc = 1; e.alu = arith(fn3, 1'b0);
        end else if (o == BEQ) begin
            e.imm = 2'b10; e.alu = 3'b001; e.pc = z;
        end else if (o == JAL) begin
            e.rw = 1; e.imm = 2'b11; e.res = 2'b10; e.pc = 1;
        end
        if (r) begin
            e.rw = 0; e.mw = 0; e.pc = 0;
        end
        e.ill = ill;
        return e;
    endfunction

    task automatic apply(bit r, bit z, bit [6:0] o, bit [2:0] fn3, bit ff7);
        @(posedge clk);
        model_ill = prev_rst ? 1'b0 : (model_ill | prev_bad);
        #1;
        rst = r; zero = z; op = o; f3 = fn3; f7 = ff7;
        q.push_back(model(r, z, o, fn3, ff7, model_ill));
        prev_rst = r;
        prev_bad = !is_legal(o);
    endtask

    task automatic chk(string name, logic [2:0] got, logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h expected %0h (op=%b f3=%b f7=%b zero=%b rst=%b)",
                     name, got, exp, op, f3, f7, zero, rst);
        end
    endtask

    // Driver
    initial begin
        bit [6:0] legal_ops [6];
        legal_ops = '{LW, SW, RTYP, BEQ, ITYP, JAL};
        rst = 1; zero = 0; op = RTYP; f3 = 0; f7 = 0;
        apply(1, 0, RTYP, 3'd0, 0);   // reset gating
        apply(1, 1, JAL, 3'd0, 0);
        apply(0, 1, BEQ, 3'd0, 0);
        apply(0, 0, BEQ, 3'd0, 0);
        apply(0, 0, JAL, 3'd0, 0);
        apply(0, 0, LW, 3'd2, 0);
        apply(0, 0, SW, 3'd2, 0);
        apply(0, 0, RTYP, 3'd0, 1);
        apply(0, 0, RTYP, 3'd0, 0);
        apply(0, 0, RTYP, 3'd2, 0);
        apply(0, 0, RTYP, 3'd6, 0);
        apply(0, 0, RTYP, 3'd7, 0);
        apply(0, 0, ITYP, 3'd0, 1);
        apply(0, 1, 7'b0000000, 3'd0, 0);
        apply(0, 1, LW, 3'd0, 0);
        apply(0, 0, RTYP, 3'd7, 1);
        apply(0, 1, BEQ, 3'd0, 0);
        apply(1, 0, LW, 3'd0, 0);
        apply(0, 0, LW, 3'd0, 0);
        apply(1, 0, 7'b1111111, 3'd0, 0); // rst wins over illegal
        apply(0, 0, SW, 3'd0, 0);
        apply(0, 0, SW, 3'd0, 0);
        for (int i = 0; i < 400; i++) begin
            bit [6:0] o;
            if ($urandom_range(0, 3) == 0) o = 7'($urandom);
            else o = legal_ops[$urandom_range(0, 5)];
            apply(($urandom_range(0, 19) == 0), 1'($urandom), o, 3'($urandom), 1'($urandom));
        end
        @(posedge clk);
        @(posedge clk);
        done = 1;
    end

    // Monitor: outputs are combinational, so each cycle presents one response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pcSrc",      {2'b0, pcSrc},    {2'b0, e.pc});
                chk("resSrc",     {1'b0, resSrc},   {1'b0, e.res});
                chk("memWrite",   {2'b0, memWrite}, {2'b0, e.mw});
                chk("aluControl", aluControl,       e.alu);
                chk("aluSrc",     {2'b0, aluSrc},   {2'b0, e.asrc});
                chk("immSrc",     {1'b0, immSrc},   {1'b0, e.imm});
                chk("regWrite",   {2'b0, regWrite}, {2'b0, e.rw});
                chk("illegal",    {2'b0, illegal},  {2'b0, e.ill});
            end else if (done) begin
                break;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d expected run to finish", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
